// File: rtl/alarm_sequencer.sv
// Alarm controller: schedules periodic sensor measurements, debounces hits against a
// threshold and runs the arm / watch / entry-delay / alarm sequence.
module alarm_sequencer #(
    parameter int unsigned THRESH      = 100,
    parameter int unsigned HITS        = 3,
    parameter int unsigned MEAS_PERIOD = 60000,
    parameter int unsigned ARM_TICKS   = 20,
    parameter int unsigned ENTRY_TICKS = 10,
    parameter int unsigned SIREN_TICKS = 100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Arm,
    output logic       Meas_Req,
    input  logic       Meas_Valid,
    input  logic [7:0] Distance,
    output logic       Siren_En,
    output logic [1:0] Tone_Sel,
    output logic [2:0] State,
    output logic       Timeout_Err
);

    localparam int unsigned PW = (MEAS_PERIOD > 1) ? $clog2(MEAS_PERIOD) : 1;
    localparam int unsigned MAX_AE = (ARM_TICKS > ENTRY_TICKS) ? ARM_TICKS : ENTRY_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_AE > SIREN_TICKS) ? MAX_AE : SIREN_TICKS;
    localparam int unsigned TW = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StArming   = 3'd1,
        StWatch    = 3'd2,
        StEntry    = 3'd3,
        StAlarm    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    hit_q, hit_d;
    logic          pending_q, pending_d;
    logic          meas_req_q, meas_req_d;
    logic          timeout_q, timeout_d;
    logic          siren_q, siren_d;
    logic [1:0]    tone_q, tone_d;

    logic          wrap;
    logic          valid_ok;
    logic          is_hit;
    logic          timed;
    logic          expire;
    int unsigned   tick_limit;

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        tick_d     = tick_q;
        hit_d      = hit_q;
        pending_d  = pending_q;
        meas_req_d = 1'b0;
        timeout_d  = 1'b0;

        wrap     = (state_q != StDisarmed) && (period_q == PW'(MEAS_PERIOD - 1));
        valid_ok = Meas_Valid && pending_q;
        is_hit   = ({24'd0, Distance} < THRESH);

        unique case (state_q)
            StArming: tick_limit = ARM_TICKS;
            StEntry:  tick_limit = ENTRY_TICKS;
            StAlarm:  tick_limit = SIREN_TICKS;
            default:  tick_limit = 0;
        endcase
        timed  = (state_q == StArming) || (state_q == StEntry) || (state_q == StAlarm);
        expire = meas_req_q && timed && ((32'(tick_q) + 32'd1) == tick_limit);

        if (state_q != StDisarmed) begin
            period_d = wrap ? '0 : period_q + PW'(1);
        end

        // A response arriving on the same edge the next request issues still counts.
        if (wrap) begin
            meas_req_d = 1'b1;
            pending_d  = 1'b1;
            timeout_d  = pending_q && !Meas_Valid;
        end else if (Meas_Valid) begin
            pending_d = 1'b0;
        end

        if (timeout_d) begin
            hit_d = '0;
        end else if (valid_ok) begin
            if (!is_hit) begin
                hit_d = '0;
            end else if (hit_q != 4'(HITS)) begin
                hit_d = hit_q + 4'd1;
            end
        end

        if (meas_req_q && timed) begin
            tick_d = tick_q + TW'(1);
        end

        unique case (state_q)
            StDisarmed: if (Arm) state_d = StArming;
            StArming:   if (expire) state_d = StWatch;
            StWatch:    if (hit_d == 4'(HITS)) state_d = StEntry;
            StEntry:    if (expire) state_d = StAlarm;
            StAlarm:    if (expire) state_d = StWatch;
            default:    state_d = StDisarmed;
        endcase

        // Re-triggering after the siren needs a fresh run of hits.
        if (state_q == StDisarmed || state_q == StArming || (state_q == StAlarm && expire)) begin
            hit_d = '0;
        end

        if (!Arm) begin
            state_d = StDisarmed;
        end

        if (state_d != state_q) begin
            tick_d = '0;
        end

        if (state_d == StDisarmed) begin
            period_d   = '0;
            tick_d     = '0;
            hit_d      = '0;
            pending_d  = 1'b0;
            meas_req_d = 1'b0;
            timeout_d  = 1'b0;
        end

        siren_d = (state_d == StAlarm);
        unique case (state_d)
            StEntry: tone_d = 2'd1;
            StAlarm: tone_d = 2'd2;
            default: tone_d = 2'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StDisarmed;
            period_q   <= '0;
            tick_q     <= '0;
            hit_q      <= '0;
            pending_q  <= 1'b0;
            meas_req_q <= 1'b0;
            timeout_q  <= 1'b0;
            siren_q    <= 1'b0;
            tone_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            tick_q     <= tick_d;
            hit_q      <= hit_d;
            pending_q  <= pending_d;
            meas_req_q <= meas_req_d;
            timeout_q  <= timeout_d;
            siren_q    <= siren_d;
            tone_q     <= tone_d;
        end
    end

    assign Meas_Req    = meas_req_q;
    assign Timeout_Err = timeout_q;
    assign Siren_En    = siren_q;
    assign Tone_Sel    = tone_q;
    assign State       = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a short measurement period and tick counts.
module tb_alarm_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Arm = 1'b0;
    logic       Meas_Req;
    logic       Meas_Valid = 1'b0;
    logic [7:0] Distance = 8'd0;
    logic       Siren_En;
    logic [1:0] Tone_Sel;
    logic [2:0] State;
    logic       Timeout_Err;

    int n_pass  = 0;
    int n_total = 0;

    alarm_sequencer #(
        .THRESH      (100),
        .HITS        (3),
        .MEAS_PERIOD (10),
        .ARM_TICKS   (2),
        .ENTRY_TICKS (2),
        .SIREN_TICKS (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Arm         (Arm),
        .Meas_Req    (Meas_Req),
        .Meas_Valid  (Meas_Valid),
        .Distance    (Distance),
        .Siren_En    (Siren_En),
        .Tone_Sel    (Tone_Sel),
        .State       (State),
        .Timeout_Err (Timeout_Err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Counts cycles until the next Meas_Req and checks the gap.
    task automatic wait_req(input int exp_gap, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!Meas_Req && n < 100);
        check(tag, n, exp_gap);
    endtask

    task automatic respond(input logic [7:0] d);
        Meas_Valid = 1'b1;
        Distance   = d;
        step();
        Meas_Valid = 1'b0;
    endtask

    task automatic answer(input logic [7:0] d);
        step();
        respond(d);
    endtask

    task automatic req_answer(input logic [7:0] d, input string tag);
        wait_req(8, tag);
        answer(d);
    endtask

    initial begin
        int reqs;

        step();
        step();
        check("rst_state", State, 0);
        check("rst_req", Meas_Req, 0);
        check("rst_siren", Siren_En, 0);
        check("rst_tone", Tone_Sel, 0);
        check("rst_timeout", Timeout_Err, 0);

        // Arming with far-away targets
        RST = 1'b0;
        Arm = 1'b1;
        step();
        check("arming_entry", State, 1);
        wait_req(10, "first_req_gap");
        check("arming_at_req1", State, 1);
        step();
        check("req_one_cycle", Meas_Req, 0);
        respond(8'd200);
        wait_req(8, "req2_gap");
        check("arming_at_req2", State, 1);
        step();
        check("watch_after_arm", State, 2);
        check("arm_siren_off", Siren_En, 0);
        respond(8'd200);

        // Detection, entry delay, siren, back to watch
        req_answer(8'd50, "det_req1");
        req_answer(8'd50, "det_req2");
        wait_req(8, "det_req3");
        step();
        check("watch_before_hit3", State, 2);
        respond(8'd50);
        check("entry_state", State, 3);
        check("entry_tone", Tone_Sel, 1);
        check("entry_siren", Siren_En, 0);
        req_answer(8'd200, "entry_tick1");
        wait_req(8, "entry_tick2");
        step();
        check("alarm_state", State, 4);
        check("alarm_siren", Siren_En, 1);
        check("alarm_tone", Tone_Sel, 2);
        respond(8'd200);
        req_answer(8'd200, "siren_tick1");
        req_answer(8'd200, "siren_tick2");
        wait_req(8, "siren_tick3");
        check("alarm_at_tick3", State, 4);
        step();
        check("rewatch_state", State, 2);
        check("rewatch_siren", Siren_En, 0);
        check("rewatch_tone", Tone_Sel, 0);
        respond(8'd200);

        // Broken hit run and the threshold boundary
        req_answer(8'd50, "brk1");
        req_answer(8'd50, "brk2");
        req_answer(8'd150, "brk3");
        req_answer(8'd50, "brk4");
        req_answer(8'd50, "brk5");
        check("no_detect_broken", State, 2);
        req_answer(8'd100, "bnd1");
        req_answer(8'd100, "bnd2");
        req_answer(8'd100, "bnd3");
        check("no_detect_boundary", State, 2);

        // Unsolicited responses are ignored
        respond(8'd50);
        step();
        respond(8'd50);
        step();
        respond(8'd50);
        check("no_detect_spurious", State, 2);
        wait_req(3, "spurious_gap");
        answer(8'd200);

        // Missed response
        req_answer(8'd50, "to_hit1");
        req_answer(8'd50, "to_hit2");
        wait_req(8, "to_missed");
        check("no_timeout_yet", Timeout_Err, 0);
        wait_req(10, "to_next_req");
        check("timeout_pulse", Timeout_Err, 1);
        step();
        check("timeout_one_cycle", Timeout_Err, 0);
        respond(8'd50);
        check("after_timeout_hit1", State, 2);
        req_answer(8'd50, "after_timeout_hit2");
        check("after_timeout_hit2_st", State, 2);
        req_answer(8'd50, "after_timeout_hit3");
        check("detect_after_timeout", State, 3);

        // Reset during entry delay
        wait_req(8, "entry_req_before_rst");
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("midrst_state", State, 0);
        check("midrst_req", Meas_Req, 0);
        check("midrst_tone", Tone_Sel, 0);
        check("midrst_siren", Siren_En, 0);
        check("midrst_timeout", Timeout_Err, 0);
        step();
        check("rearm_after_rst", State, 1);
        wait_req(10, "rst_rearm_gap");
        answer(8'd200);
        req_answer(8'd200, "rst_arm_tick2");
        check("rst_watch", State, 2);
        req_answer(8'd50, "rst_hit1");
        req_answer(8'd50, "rst_hit2");
        req_answer(8'd50, "rst_hit3");
        check("rst_entry", State, 3);
        req_answer(8'd200, "rst_entry_tick1");
        wait_req(8, "rst_entry_tick2");
        step();
        check("alarm_before_disarm", Siren_En, 1);

        // Disarm during the siren
        Arm = 1'b0;
        step();
        check("disarm_state", State, 0);
        check("disarm_siren", Siren_En, 0);
        check("disarm_tone", Tone_Sel, 0);
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (Meas_Req) reqs++;
        end
        check("disarm_no_req", reqs, 0);
        Arm = 1'b1;
        step();
        check("rearm_state", State, 1);
        wait_req(10, "rearm_full_delay");
        check("rearm_still_arming", State, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Top-level alarm controller for the ultrasonic security system. Schedules HC-SR04 measurements by issuing periodic requests to the sensor controller and qualifies the returned 8-bit distances against a threshold. It runs the arm / watch / entry-delay / alarm state machine and drives the enables to the sound generator and codec clock gating. It replaces the inline distance compare on the codec clock with a debounced, timed decision.

Parameters:
THRESH, 100, detection threshold; a sample is a hit when Distance < THRESH
HITS, 3, consecutive hit samples required to detect (1..15)
MEAS_PERIOD, 60000, CLK cycles between measurement requests (>=4)
ARM_TICKS, 20, measurement periods from arming until the watch begins
ENTRY_TICKS, 10, measurement periods of entry delay before the siren
SIREN_TICKS, 100, measurement periods the siren sounds

Ports:
CLK  in  1  system clock (T_CLK domain)
RST  in  1  reset, synchronous, active-high
Arm  in  1  level; 1 = system armed, 0 = disarm (pre-synchronised)
Meas_Req  out  1  one-cycle pulse that starts one sensor measurement
Meas_Valid  in  1  one-cycle pulse; Distance is valid
Distance  in  8  measured distance in cm
Siren_En  out  1  enables Sound_Generator and the codec clock
Tone_Sel  out  2  0 = silent, 1 = entry chirp, 2 = siren
State  out  3  0 DISARMED, 1 ARMING, 2 WATCH, 3 ENTRY, 4 ALARM
Timeout_Err  out  1  one-cycle pulse when a request gets no Meas_Valid

Behaviour:
- Reset: State=DISARMED; Meas_Req=0, Siren_En=0, Tone_Sel=0, Timeout_Err=0; all counters and the outstanding flag are 0. All outputs are registered.
- Scheduler: a period counter runs only when State != DISARMED. It counts 0..MEAS_PERIOD-1 and wraps. Meas_Req pulses on the cycle after the wrap. The first request comes MEAS_PERIOD cycles after leaving DISARMED. Each Meas_Req is one "tick".
- Outstanding flag: set by Meas_Req and cleared by Meas_Valid.
  - If the flag is still set when the next Meas_Req issues, Timeout_Err pulses in the same cycle as that Meas_Req, and the missed sample counts as a non-hit.
  - Meas_Valid in the same cycle as Meas_Req satisfies the previous request, so no timeout.
  - Meas_Valid with no outstanding request is ignored.
- Hit counter (4 bit):
  - Meas_Valid with Distance < THRESH increments the counter, saturating at HITS.
  - A non-hit valid sample or a timeout clears it.
  - The counter is held at 0 in DISARMED and ARMING.
  - Detect = the counter reaches HITS, registered one cycle after the qualifying Meas_Valid.
  - Distance == THRESH is a non-hit.
- Tick counter: cleared on every state entry. It increments on each Meas_Req in ARMING, ENTRY and ALARM. A timed state exits on the edge after its Nth Meas_Req.
- Transitions (Arm=0 has top priority from every state and moves to DISARMED on the next edge, clearing all counters):
  - DISARMED -> ARMING when Arm=1.
  - ARMING -> WATCH after ARM_TICKS ticks.
  - WATCH -> ENTRY on detect.
  - ENTRY -> ALARM after ENTRY_TICKS ticks. Detections are ignored in ENTRY.
  - ALARM -> WATCH after SIREN_TICKS ticks, with the hit counter cleared, so re-triggering needs HITS fresh hits.
- Outputs by state: Siren_En=1 only in ALARM. Tone_Sel=1 in ENTRY, 2 in ALARM, 0 otherwise. State mirrors the state register.
- Simultaneous events:
  - Arm falling in the same cycle as detect or a tick expiry -> DISARMED.
  - Meas_Valid and a tick expiry in the same cycle: the state transition and the hit update both apply.
- RST asserted mid-operation returns everything to reset values on the next edge, including dropping an active siren.

Test Plan:
Bench parameters for all scenarios: MEAS_PERIOD=10, ARM_TICKS=2, ENTRY_TICKS=2, SIREN_TICKS=3, HITS=3, THRESH=100.

1. Arm=1 after reset, answer every Meas_Req with Distance=200 -> Meas_Req every 10 cycles, first 10 cycles after ARMING. State is ARMING, then WATCH after the 2nd request. Siren_En stays 0.
2. In WATCH, answer Distance=50, 50, 50 -> ENTRY one cycle after the 3rd Meas_Valid with Tone_Sel=1. After 2 ticks, ALARM with Siren_En=1 and Tone_Sel=2. After 3 more ticks, WATCH with Siren_En=0.
3. In WATCH, answer 50, 50, 150, 50, 50 -> no detect. Also Distance=100 three times -> no detect (boundary value).
4. In WATCH, answer 50, 50, then no Meas_Valid -> Timeout_Err pulses with the next Meas_Req. The following 50 does not detect; two further 50s do detect.
5. In ALARM, drop Arm to 0 -> next edge State=DISARMED, Siren_En=0, Tone_Sel=0, and no further Meas_Req. Re-arm -> full ARMING delay again.
6. Assert RST for 1 cycle during ENTRY -> all outputs at reset values on the next edge. Meas_Valid pulses with no outstanding request have no effect.
